// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC accumulator slice.
//   mac_state_t : dump FSM state (ACCUM, DUMP_HI, DUMP_LO)
//   MAC_PROD_W  : product width from the multiplier
//   MAC_ACC_W   : accumulator width (twice the product width)
//   MAC_CNT_MAX : saturation value of the accepted-product counter
package mac_pkg;
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DUMP_HI = 2'd1,
        DUMP_LO = 2'd2
    } mac_state_t;
    localparam int MAC_PROD_W  = 8;
    localparam int MAC_ACC_W   = 16;
    localparam int MAC_CNT_MAX = 255;
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational ACC_W+1-bit add of accumulator and product.
//   acc   in  ACC_W   current accumulator
//   prod  in  PROD_W  unsigned product
//   sum   out ACC_W   next accumulator value (wrapped or saturated)
//   carry out 1       carry-out of the ACC_W-bit add
// Build option: MAC_SAT_EN defined -> saturate at all-ones on carry,
// otherwise the sum wraps modulo 2^ACC_W.
module mac_sat_add import mac_pkg::*; #(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;
    assign full  = {1'b0, acc} + {{(ACC_W-PROD_W+1){1'b0}}, prod};
    assign carry = full[ACC_W];
`ifdef MAC_SAT_EN
    // once pinned at all-ones, any nonzero product carries again, so it sticks
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums multiplier products and dumps the sum as two bytes.
//   clk, rst    clock; synchronous active-high reset
//   ena         tile enable; low freezes all state
//   prod_valid  product valid; prod  unsigned product
//   prod_ready  product accepted this cycle (ACCUM state, enabled, not in reset)
//   acc_clear   zero accumulator, count and overflow flag
//   dump_req    start high-then-low byte dump
//   out_valid, out_byte, out_last  dump byte stream (last marks low byte)
//   acc_count   products accepted since last clear, saturating at 255
//   overflow    sticky accumulator carry-out flag
// Build option: MAC_SAT_EN selects saturating instead of wrapping adds.
module mac_accumulator import mac_pkg::*; #(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    input  logic              acc_clear,
    input  logic              dump_req,
    output logic              out_valid,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [7:0]        acc_count,
    output logic              overflow
);
    mac_state_t       state, state_n;
    logic [ACC_W-1:0] acc, acc_n, sum;
    logic [7:0]       cnt_n;
    logic             ovf_n, carry, accept;

    mac_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc  (acc),
        .prod (prod),
        .sum  (sum),
        .carry(carry)
    );

    assign prod_ready = ena & ~rst & (state == ACCUM);
    assign accept     = prod_valid & prod_ready;
    assign out_valid  = state != ACCUM;
    assign out_last   = state == DUMP_LO;
    assign out_byte   = state == DUMP_HI ? acc[ACC_W-1 -: 8] :
                        state == DUMP_LO ? acc[7:0] : 8'h00;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = acc_count;
        ovf_n   = overflow;
        case (state)
            ACCUM: begin
                // a clear with a product restarts the run from that product
                if (acc_clear) begin
                    acc_n = accept ? {{(ACC_W-PROD_W){1'b0}}, prod} : '0;
                    cnt_n = accept ? 8'd1 : 8'd0;
                    ovf_n = 1'b0;
                end else if (accept) begin
                    acc_n = sum;
                    cnt_n = acc_count == 8'(MAC_CNT_MAX) ? acc_count : acc_count + 8'd1;
                    ovf_n = overflow | carry;
                end
                state_n = dump_req ? DUMP_HI : ACCUM;
            end
            DUMP_HI: state_n = DUMP_LO;
            DUMP_LO: begin
                state_n = ACCUM;
                acc_n   = '0;
                cnt_n   = 8'd0;
                ovf_n   = 1'b0;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            acc_count <= 8'd0;
            overflow  <= 1'b0;
        end else if (ena) begin
            state     <= state_n;
            acc       <= acc_n;
            acc_count <= cnt_n;
            overflow  <= ovf_n;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: vector table, corner sequences and random run vs a queue model.
module tb_mac_accumulator;
    logic       clk = 0, rst = 1, ena = 1, prod_valid = 0, acc_clear = 0, dump_req = 0;
    logic [7:0] prod = 0;
    logic       prod_ready, out_valid, out_last, overflow;
    logic [7:0] out_byte, acc_count;
    int total = 0, bad = 0;

    mac_accumulator dut (
        .clk(clk), .rst(rst), .ena(ena), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(prod_ready), .acc_clear(acc_clear), .dump_req(dump_req),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .acc_count(acc_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        int         n;
        logic [7:0] hi, lo, cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic accum(input logic [7:0] p, input int n);
        prod_valid = 1;
        prod = p;
        repeat (n) tick();
        prod_valid = 0;
    endtask

    task automatic dump(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        dump_req = 1;
        tick();
        dump_req = 0;
        chk({tag, " hi valid"}, out_valid, 1);
        chk({tag, " hi byte"}, out_byte, hi);
        chk({tag, " hi last"}, out_last, 0);
        chk({tag, " hi ready"}, prod_ready, 0);
        tick();
        chk({tag, " lo valid"}, out_valid, 1);
        chk({tag, " lo byte"}, out_byte, lo);
        chk({tag, " lo last"}, out_last, 1);
        tick();
        chk({tag, " post valid"}, out_valid, 0);
        chk({tag, " post ready"}, prod_ready, 1);
        chk({tag, " post count"}, acc_count, 0);
        chk({tag, " post ovf"}, overflow, 0);
    endtask

    // reference model: unbounded running sum, product count, pending dump bytes
    int         m_sum, m_n;
    logic [7:0] m_pend[$];

    function automatic int m_acc();
`ifdef MAC_SAT_EN
        return m_sum > 65535 ? 65535 : m_sum;
`else
        return m_sum % 65536;
`endif
    endfunction

    initial begin
        vecs[0] = '{8'h01, 1,   8'h00, 8'h01, 8'd1,   1'b0};
        vecs[1] = '{8'hFF, 4,   8'h03, 8'hFC, 8'd4,   1'b0};
        vecs[2] = '{8'h80, 10,  8'h05, 8'h00, 8'd10,  1'b0};
        vecs[3] = '{8'h00, 5,   8'h00, 8'h00, 8'd5,   1'b0};
        vecs[4] = '{8'hFF, 257, 8'hFF, 8'hFF, 8'd255, 1'b0};
`ifdef MAC_SAT_EN
        vecs[5] = '{8'hE1, 300, 8'hFF, 8'hFF, 8'd255, 1'b1};
        vecs[6] = '{8'hFF, 258, 8'hFF, 8'hFF, 8'd255, 1'b1};
`else
        vecs[5] = '{8'hE1, 300, 8'h07, 8'hAC, 8'd255, 1'b1};
        vecs[6] = '{8'hFF, 258, 8'h00, 8'hFE, 8'd255, 1'b1};
`endif
        tick();
        tick();
        chk("rst ready", prod_ready, 0);
        chk("rst valid", out_valid, 0);
        chk("rst byte", out_byte, 0);
        chk("rst last", out_last, 0);
        chk("rst count", acc_count, 0);
        chk("rst ovf", overflow, 0);
        rst = 0;
        #1;
        chk("ready after rst", prod_ready, 1);

        accum(8'h10, 1);
        accum(8'h20, 1);
        accum(8'h30, 1);
        chk("seq3 count", acc_count, 3);
        dump("seq3", 8'h00, 8'h60);

        foreach (vecs[i]) begin
            accum(vecs[i].p, vecs[i].n);
            chk($sformatf("vec%0d count", i), acc_count, vecs[i].cnt);
            chk($sformatf("vec%0d ovf", i), overflow, vecs[i].ovf);
            dump($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        accum(8'h40, 1);
        acc_clear = 1;
        accum(8'h05, 1);
        acc_clear = 0;
        chk("clr count", acc_count, 1);
        dump("clr", 8'h00, 8'h05);

        accum(8'h11, 1);
        prod_valid = 1;
        prod = 8'h22;
        dump("dmp+prod", 8'h00, 8'h33);
        prod_valid = 0;

        accum(8'h07, 2);
        ena = 0;
        prod_valid = 1;
        prod = 8'hFF;
        repeat (4) begin
            #1;
            chk("ena0 ready", prod_ready, 0);
            tick();
            chk("ena0 count", acc_count, 2);
            chk("ena0 valid", out_valid, 0);
        end
        prod_valid = 0;
        ena = 1;
        dump("ena0", 8'h00, 8'h0E);

        accum(8'h09, 1);
        dump_req = 1;
        tick();
        dump_req = 0;
        chk("rstdump hi valid", out_valid, 1);
        rst = 1;
        tick();
        chk("rstdump valid", out_valid, 0);
        chk("rstdump ready in rst", prod_ready, 0);
        rst = 0;
        #1;
        chk("rstdump ready", prod_ready, 1);
        chk("rstdump count", acc_count, 0);
        tick();
        chk("rstdump no lo", out_valid, 0);
        dump("rstdump", 8'h00, 8'h00);

        m_sum = 0;
        m_n = 0;
        for (int i = 0; i < 3000; i++) begin
            ena        = $urandom_range(99) < 90;
            prod_valid = $urandom_range(99) < 70;
            prod       = 8'($urandom_range(255));
            acc_clear  = $urandom_range(99) < (i < 1500 ? 3 : 0);
            dump_req   = $urandom_range(999) < (i < 1500 ? 50 : 2);
            #1;
            chk("rnd ready", prod_ready, ena && m_pend.size() == 0);
            if (ena) begin
                if (m_pend.size() != 0) begin
                    void'(m_pend.pop_front());
                    if (m_pend.size() == 0) begin
                        m_sum = 0;
                        m_n = 0;
                    end
                end else begin
                    if (acc_clear) begin
                        m_sum = prod_valid ? int'(prod) : 0;
                        m_n = prod_valid ? 1 : 0;
                    end else if (prod_valid) begin
                        m_sum += int'(prod);
                        m_n++;
                    end
                    if (dump_req) begin
                        m_pend.push_back(8'(m_acc() >> 8));
                        m_pend.push_back(8'(m_acc()));
                    end
                end
            end
            tick();
            chk("rnd valid", out_valid, m_pend.size() != 0);
            if (m_pend.size() != 0) begin
                chk("rnd byte", out_byte, m_pend[0]);
                chk("rnd last", out_last, m_pend.size() == 1);
            end
            chk("rnd count", acc_count, m_n > 255 ? 255 : m_n);
            chk("rnd ovf", overflow, m_sum > 65535);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
